// File: rtl/lsu_arb_pkg.sv
// rtl/lsu_arb_pkg.sv - shared types and LSU command codes for the LSU arbiter
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] LS_NONE  = 2'b00;
  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  function automatic logic [1:0] ls_code(input logic we);
    return we ? LS_STORE : LS_LOAD;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_valid_o
);

  always_comb begin
    any_valid_o = |valid_i;
    case (valid_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_arbiter.sv
// rtl/lsu_arbiter.sv - shares one UART-backed LSU between fetch (port 0) and data (port 1)
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        lsu_en_ls,
  output logic [ADDR_W-1:0] lsu_address,
  output logic [DATA_W-1:0] lsu_wdata,
  input  logic              lsu_done,
  input  logic              rx_do,
  input  logic [7:0]        rx_data
);

  state_e            state_q;
  logic              last_grant_q;
  logic              gnt_q;
  logic              we_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [1:0]        en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp0_q, resp1_q;
  logic [DATA_W-1:0] rdata_q;

  logic grant;
  logic any_valid;

  rr_arb2 u_rr (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .any_valid_o  (any_valid)
  );

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && (grant == 1'b0);
  assign req1_ready = (state_q == ST_IDLE) && req1_valid && (grant == 1'b1);

  // Byte capture is computed ahead so an rx_do coincident with lsu_done still lands in the response.
  always_comb begin
    rbuf_d     = rbuf_q;
    byte_cnt_d = byte_cnt_q;
    if (state_q == ST_BUSY && !we_q && rx_do) begin
      if (byte_cnt_q == 2'd0) begin
        rbuf_d[DATA_W-1 -: 8] = rx_data;
        byte_cnt_d            = 2'd1;
      end else if (byte_cnt_q == 2'd1) begin
        rbuf_d[7:0] = rx_data;
        byte_cnt_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      byte_cnt_q   <= 2'd0;
      rbuf_q       <= '0;
      en_q         <= LS_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp0_q      <= 1'b0;
      resp1_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          en_q    <= LS_NONE;
          if (any_valid) begin
            gnt_q      <= grant;
            we_q       <= grant ? req1_we : req0_we;
            addr_q     <= grant ? req1_addr : req0_addr;
            wdata_q    <= grant ? req1_wdata : req0_wdata;
            en_q       <= ls_code(grant ? req1_we : req0_we);
            rbuf_q     <= '0;
            byte_cnt_q <= 2'd0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          rbuf_q     <= rbuf_d;
          byte_cnt_q <= byte_cnt_d;
          if (lsu_done) begin
            // Dropping en_ls here keeps the now-idle LSU from starting again.
            en_q         <= LS_NONE;
            resp0_q      <= (gnt_q == 1'b0);
            resp1_q      <= (gnt_q == 1'b1);
            rdata_q      <= we_q ? '0 : rbuf_d;
            last_grant_q <= gnt_q;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          en_q    <= LS_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lsu_en_ls   = en_q;
  assign lsu_address = addr_q;
  assign lsu_wdata   = wdata_q;
  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb/tb_lsu_arbiter.sv - self-checking bench for lsu_arbiter
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [7:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [15:0] resp_rdata;
  logic [1:0]  lsu_en_ls;
  logic [7:0]  lsu_address;
  logic [15:0] lsu_wdata;
  logic        lsu_done, rx_do;
  logic [7:0]  rx_data;

  always #5 clk = ~clk;

  lsu_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp_rdata  (resp_rdata),
    .lsu_en_ls   (lsu_en_ls),
    .lsu_address (lsu_address),
    .lsu_wdata   (lsu_wdata),
    .lsu_done    (lsu_done),
    .rx_do       (rx_do),
    .rx_data     (rx_data)
  );

  typedef struct {
    logic [1:0]  valid;
    logic        we;
    logic [7:0]  a0, a1;
    logic [15:0] w0, w1;
    int          nb;
    logic [23:0] bytes;
    logic        coinc;
    logic        exp_port;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   rdy0_cnt = 0, rdy1_cnt = 0;
  int   exp_g0 = 0, exp_g1 = 0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] valid, input logic we,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input int nb, input logic [23:0] bytes, input logic coinc,
                              input logic exp_port, input logic [15:0] exp_rdata);
    vec_t v;
    v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.nb = nb; v.bytes = bytes; v.coinc = coinc;
    v.exp_port = exp_port; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Response monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (req0_ready) rdy0_cnt++;
    if (req1_ready) rdy1_cnt++;
    if (!reset && (resp0_valid || resp1_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_resp actual=%b%b required=00", resp1_valid, resp0_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_port", {30'd0, resp1_valid, resp0_valid}, mon_e.port ? 32'd2 : 32'd1);
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, mon_e.rdata});
        chk("resp_en_none", {30'd0, lsu_en_ls}, 32'd0);
        chk("resp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic        found;
    logic [7:0]  ea;
    logic [15:0] ew;
    logic [1:0]  een;
    exp_t        e;
    req0_valid = v.valid[0]; req1_valid = v.valid[1];
    req0_we = v.we; req1_we = v.we;
    req0_addr = v.a0; req1_addr = v.a1;
    req0_wdata = v.w0; req1_wdata = v.w1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    chk("grant", {30'd0, req1_ready, req0_ready}, v.exp_port ? 32'd2 : 32'd1);
    if (v.exp_port) exp_g1++; else exp_g0++;
    e.port = v.exp_port; e.rdata = v.exp_rdata;
    sb.push_back(e);
    ea  = v.exp_port ? v.a1 : v.a0;
    ew  = v.exp_port ? v.w1 : v.w0;
    een = v.we ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    for (int i = 0; i < v.nb; i++) begin
      rx_data  = 8'(v.bytes >> (16 - 8 * i));
      rx_do    = 1'b1;
      lsu_done = v.coinc && (i == v.nb - 1);
      @(negedge clk);
      chk("busy_en", {30'd0, lsu_en_ls}, {30'd0, een});
      chk("busy_addr", {24'd0, lsu_address}, {24'd0, ea});
      chk("busy_wdata", {16'd0, lsu_wdata}, {16'd0, ew});
      @(posedge clk); #1;
      rx_do = 1'b0; lsu_done = 1'b0;
    end
    if (!(v.coinc && v.nb > 0)) begin
      lsu_done = 1'b1;
      @(negedge clk);
      chk("busy_en_done", {30'd0, lsu_en_ls}, {30'd0, een});
      @(posedge clk); #1;
      lsu_done = 1'b0;
    end
    @(posedge clk); #1;
    chk("resp_seen", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
    req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0;
    lsu_done = 0; rx_do = 0; rx_data = 0;

    //       valid  we    a0     a1     w0        w1        nb bytes       co  port rdata
    vecs[0] = mk(2'b01, 1'b0, 8'h12, 8'h00, 16'h0000, 16'h0000, 2, 24'hABCD00, 0, 0, 16'hABCD);
    vecs[1] = mk(2'b10, 1'b1, 8'h00, 8'h40, 16'h0000, 16'hBEEF, 1, 24'h550000, 0, 1, 16'h0000);
    vecs[2] = mk(2'b11, 1'b0, 8'h20, 8'hA0, 16'h0000, 16'h0000, 2, 24'h010200, 0, 0, 16'h0102);
    vecs[3] = mk(2'b11, 1'b1, 8'h21, 8'hA1, 16'h1111, 16'h2222, 0, 24'h000000, 0, 1, 16'h0000);
    vecs[4] = mk(2'b11, 1'b0, 8'h22, 8'hA2, 16'h0000, 16'h0000, 2, 24'h030400, 0, 0, 16'h0304);
    vecs[5] = mk(2'b11, 1'b0, 8'h23, 8'hA3, 16'h0000, 16'h0000, 2, 24'h050600, 0, 1, 16'h0506);
    vecs[6] = mk(2'b01, 1'b0, 8'h30, 8'h00, 16'h0000, 16'h0000, 3, 24'h112233, 0, 0, 16'h1122);
    vecs[7] = mk(2'b10, 1'b0, 8'h00, 8'h31, 16'h0000, 16'h0000, 1, 24'h770000, 0, 1, 16'h7700);
    vecs[8] = mk(2'b01, 1'b0, 8'h32, 8'h00, 16'h0000, 16'h0000, 2, 24'h9ABC00, 1, 0, 16'h9ABC);
    vecs[9] = mk(2'b11, 1'b0, 8'h34, 8'hB4, 16'h0000, 16'h0000, 2, 24'h123400, 0, 0, 16'h1234);

    @(negedge clk);
    chk("rst_en", {30'd0, lsu_en_ls}, 32'd0);
    chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_addr", {24'd0, lsu_address}, 32'd0);
    chk("rst_wdata", {16'd0, lsu_wdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);
    req0_valid = 0; req1_valid = 0;

    // Spurious lsu_done while idle.
    lsu_done = 1'b1;
    @(posedge clk); #1;
    lsu_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_done_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      chk("idle_done_en", {30'd0, lsu_en_ls}, 32'd0);
    end

    // Reset in the middle of a load after one byte.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h33;
    @(negedge clk);
    chk("rstmid_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
    exp_g0++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rx_do = 1'b1; rx_data = 8'hEE;
    @(posedge clk); #1;
    rx_do = 1'b0;
    @(negedge clk);
    chk("rstmid_busy_en", {30'd0, lsu_en_ls}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_async_en", {30'd0, lsu_en_ls}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(vecs[9]);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;

    chk("ready0_count", rdy0_cnt, exp_g0);
    chk("ready1_count", rdy1_cnt, exp_g1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
